// File: rtl/i_deser_pkg.sv
// Shared definitions for the SDR input deserializer:
// auto-align state encoding, width limits and counter sizing.
package i_deser_pkg;

   localparam int MAX_WIDTH = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   function automatic int cnt_w(input int w);
      int lim;
      lim = (w > MAX_WIDTH) ? MAX_WIDTH : w;
      return (lim > 1) ? $clog2(lim) : 1;
   endfunction

endpackage

// File: rtl/i_deser_align_fsm.sv
// Training-pattern search: requests a slip after each mismatching
// word and declares lock after LOCK_COUNT consecutive matches.
module i_deser_align_fsm
   import i_deser_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = '0,
   parameter int               LOCK_COUNT    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             data_valid,
   input  logic [WIDTH-1:0] q,
   output logic             slip,
   output logic             locked
);

   state_e     state_q, state_d;
   logic [3:0] match_q, match_d;
   logic       locked_q, locked_d;

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      slip    = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
         match_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_SEARCH;
               match_d = '0;
            end
            ST_SEARCH: begin
               if (data_valid) begin
                  if (q == TRAIN_PATTERN) begin
                     match_d = match_q + 4'd1;
                     if (match_q == 4'(LOCK_COUNT - 1))
                        state_d = ST_LOCKED;
                  end else begin
                     // slip lands on the cnt==0 edge right after the bad word
                     match_d = '0;
                     slip    = 1'b1;
                  end
               end
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_IDLE;
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         match_q  <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         locked_q <= locked_d;
      end
   end

   assign locked = locked_q;

endmodule

// File: rtl/i_deser_align.sv
// SDR serial-to-parallel receiver, MSB first, with manual bitslip
// or automatic alignment against a training word.
module i_deser_align
   import i_deser_pkg::*;
#(
   parameter int               WIDTH         = 4,
   parameter string            AUTO_ALIGN    = "FALSE",
   parameter logic [WIDTH-1:0] TRAIN_PATTERN = 4'hC,
   parameter int               LOCK_COUNT    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             D,
   input  logic             EN,
   input  logic             BITSLIP,
   output logic [WIDTH-1:0] Q,
   output logic             DATA_VALID,
   output logic             LOCKED
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam bit            AUTO = (AUTO_ALIGN == "TRUE");

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dv_q, dv_d;
   logic             bs_q, bs_d;
   logic             guard_q, guard_d;
   logic             man_req, slip;
   logic             auto_slip, auto_locked;

   i_deser_align_fsm #(
      .WIDTH         (WIDTH),
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .LOCK_COUNT    (LOCK_COUNT)
   ) u_fsm (
      .clk        (CLK),
      .rst        (RST),
      .en         (EN),
      .data_valid (dv_q),
      .q          (q_q),
      .slip       (auto_slip),
      .locked     (auto_locked)
   );

   always_comb begin
      man_req = BITSLIP & ~bs_q & ~guard_q;
      slip    = EN & (AUTO ? auto_slip : man_req);
      sr_d    = sr_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dv_d    = 1'b0;
      bs_d    = BITSLIP;
      guard_d = guard_q;
      if (!EN) begin
         sr_d    = '0;
         cnt_d   = '0;
         guard_d = 1'b0;
      end else begin
         sr_d = {sr_q[WIDTH-2:0], D};
         if (slip) begin
            // counter holds, so this word absorbs one extra bit
            guard_d = 1'b1;
         end else if (cnt_q == LAST) begin
            q_d     = {sr_q[WIDTH-2:0], D};
            dv_d    = 1'b1;
            cnt_d   = '0;
            guard_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sr_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dv_q    <= 1'b0;
         bs_q    <= 1'b0;
         guard_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dv_q    <= dv_d;
         bs_q    <= bs_d;
         guard_q <= guard_d;
      end
   end

   assign Q          = q_q;
   assign DATA_VALID = dv_q;
   assign LOCKED     = AUTO ? auto_locked : 1'b0;

endmodule

// File: tb/tb_i_deser_align.sv
// Bench for i_deser_align: one manual and one auto-align instance
// on a shared serial stream, expected words held in a queue.
module tb_i_deser_align;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d   = 1'b0;
   logic       en  = 1'b0;
   logic       bs  = 1'b0;
   logic [3:0] q_m, q_a;
   logic       dv_m, dv_a, lk_m, lk_a;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [3:0] exp_q[$];
   logic [3:0] w;

   i_deser_align #(
      .WIDTH(4), .AUTO_ALIGN("FALSE"),
      .TRAIN_PATTERN(4'hC), .LOCK_COUNT(4)
   ) u_man (
      .CLK(clk), .RST(rst), .D(d), .EN(en), .BITSLIP(bs),
      .Q(q_m), .DATA_VALID(dv_m), .LOCKED(lk_m)
   );

   i_deser_align #(
      .WIDTH(4), .AUTO_ALIGN("TRUE"),
      .TRAIN_PATTERN(4'hC), .LOCK_COUNT(4)
   ) u_auto (
      .CLK(clk), .RST(rst), .D(d), .EN(en), .BITSLIP(bs),
      .Q(q_a), .DATA_VALID(dv_a), .LOCKED(lk_a)
   );

   always #5 clk = ~clk;

   function automatic logic sb(input int n);
      return ((n % 4) < 2);
   endfunction

   task automatic tick(input logic di, input logic ei,
                       input logic bi, input logic ri);
      @(negedge clk);
      d = di; en = ei; bs = bi; rst = ri;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, (i % 2 == 1), 1'b1);
         n_chk++;
         if ({q_m, dv_m, lk_m, q_a, dv_a, lk_a} !== 12'h0)
            $display("FAIL reset_hold: got q_m=%h dv_m=%b lk_m=%b q_a=%h dv_a=%b lk_a=%b want all 0",
                     q_m, dv_m, lk_m, q_a, dv_a, lk_a);
         else n_pass++;
      end
      exp_q.delete();
      exp_q.push_back(4'hF);
      for (int e = 1; e <= 4; e++) begin
         tick(1'b1, 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (dv_m !== (e == 4))
            $display("FAIL reset_first_word e%0d: dv got %b want %b", e, dv_m, (e == 4));
         else n_pass++;
         if (dv_m === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_m !== w) $display("FAIL reset_word: q got %h want %h", q_m, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL reset_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_manual();
      logic [7:0] bits;
      bits = 8'b1011_0110;
      do_reset();
      exp_q.delete();
      exp_q.push_back(4'hB);
      exp_q.push_back(4'h6);
      for (int e = 1; e <= 8; e++) begin
         tick(bits[8-e], 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (dv_m !== (e == 4 || e == 8))
            $display("FAIL manual_dv e%0d: got %b want %b", e, dv_m, (e == 4 || e == 8));
         else n_pass++;
         if (dv_m === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_m !== w) $display("FAIL manual_word e%0d: q got %h want %h", e, q_m, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL manual_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_bitslip();
      logic want_dv, slip_in;
      do_reset();
      exp_q.delete();
      exp_q.push_back(4'h9);
      exp_q.push_back(4'h3);
      exp_q.push_back(4'h6);
      exp_q.push_back(4'h6);
      for (int e = 1; e <= 18; e++) begin
         slip_in = (e == 5 || e == 7 || e == 10);
         tick(sb(e), 1'b1, slip_in, 1'b0);
         want_dv = (e == 4 || e == 9 || e == 14 || e == 18);
         n_chk++;
         if (dv_m !== want_dv)
            $display("FAIL bitslip_dv e%0d: got %b want %b", e, dv_m, want_dv);
         else n_pass++;
         if (dv_m === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_m !== w) $display("FAIL bitslip_word e%0d: q got %h want %h", e, q_m, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL bitslip_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      logic [4:0] post;
      post = 5'b11001;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      n_chk++;
      if (q_m !== 4'h0 || dv_m !== 1'b0)
         $display("FAIL simul_rst: got q=%h dv=%b want q=0 dv=0", q_m, dv_m);
      else n_pass++;
      exp_q.delete();
      exp_q.push_back(4'h9);
      for (int e = 5; e <= 9; e++) begin
         tick(post[9-e], 1'b1, (e == 6), 1'b0);
         n_chk++;
         if (dv_m !== (e == 9))
            $display("FAIL simul_dv e%0d: got %b want %b", e, dv_m, (e == 9));
         else n_pass++;
         if (dv_m === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_m !== w) $display("FAIL simul_word: q got %h want %h", q_m, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL simul_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
   endtask

   task automatic test_auto_align();
      logic want_dv;
      do_reset();
      exp_q.delete();
      exp_q.push_back(4'h9);
      exp_q.push_back(4'h3);
      exp_q.push_back(4'h6);
      for (int i = 0; i < 6; i++) exp_q.push_back(4'hC);
      for (int e = 1; e <= 40; e++) begin
         tick(sb(e), 1'b1, (e % 3 == 0), 1'b0);
         want_dv = e inside {4, 9, 14, 19, 23, 27, 31, 35, 39};
         n_chk++;
         if (dv_a !== want_dv)
            $display("FAIL auto_dv e%0d: got %b want %b", e, dv_a, want_dv);
         else n_pass++;
         n_chk++;
         if (lk_a !== (e >= 32))
            $display("FAIL auto_locked e%0d: got %b want %b", e, lk_a, (e >= 32));
         else n_pass++;
         if (dv_a === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_a !== w) $display("FAIL auto_word e%0d: q got %h want %h", e, q_a, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL auto_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
      n_chk++;
      if (lk_m !== 1'b0) $display("FAIL manual_locked: got %b want 0", lk_m);
      else n_pass++;
   endtask

   task automatic test_en_drop();
      logic [3:0] nb;
      nb = 4'hA;
      tick(sb(41), 1'b1, 1'b0, 1'b0);
      tick(sb(42), 1'b1, 1'b0, 1'b0);
      for (int e = 43; e <= 45; e++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         n_chk++;
         if (dv_a !== 1'b0 || lk_a !== 1'b0 || q_a !== 4'hC)
            $display("FAIL en_drop e%0d: got dv=%b lk=%b q=%h want dv=0 lk=0 q=c",
                     e, dv_a, lk_a, q_a);
         else n_pass++;
      end
      exp_q.delete();
      exp_q.push_back(4'hA);
      for (int e = 1; e <= 4; e++) begin
         tick(nb[4-e], 1'b1, 1'b0, 1'b0);
         n_chk++;
         if (dv_a !== (e == 4) || lk_a !== 1'b0)
            $display("FAIL en_resume e%0d: got dv=%b lk=%b want dv=%b lk=0",
                     e, dv_a, lk_a, (e == 4));
         else n_pass++;
         if (dv_a === 1'b1 && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            n_chk++;
            if (q_a !== w) $display("FAIL en_resume_word: q got %h want %h", q_a, w);
            else n_pass++;
         end
      end
      n_chk++;
      if (exp_q.size() != 0) $display("FAIL en_missing: %0d words left want 0", exp_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_manual();
      test_bitslip();
      test_simultaneous();
      test_auto_align();
      test_en_drop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
